// File: rtl/core_alu_pkg.sv
// Shared types and constants for the core ALU arbiter slice.
// Opcode encoding matches the core ALU's alu_op_i.
package core_alu_pkg;

  localparam int DATA_W      = 16;
  localparam int ALU_LATENCY = 1;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'd0,
    ALU_SUB    = 3'd1,
    ALU_AND    = 3'd2,
    ALU_XOR    = 3'd3,
    ALU_SHL    = 3'd4,
    ALU_SHR    = 3'd5,
    ALU_PASS_A = 3'd6,
    ALU_PASS_B = 3'd7
  } alu_op_e;

endpackage

// File: rtl/core_alu_rsp_fifo.sv
// Two-entry response FIFO of {data, tag} for one requester.
// The head entry lives in a flop, so head outputs are registered.
module core_alu_rsp_fifo
  import core_alu_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic [TAG_W-1:0]  push_tag_i,
  input  logic              pop_i,
  output logic [1:0]        count_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic [TAG_W-1:0]  head_tag_o
);

  localparam int W = DATA_W + TAG_W;

  logic [W-1:0] e0_q, e0_d;
  logic [W-1:0] e1_q, e1_d;
  logic [W-1:0] din;
  logic [1:0]   cnt_q, cnt_d;
  logic         pop_ok;

  assign din    = {push_data_i, push_tag_i};
  assign pop_ok = pop_i && (cnt_q != 2'd0);

  // Next-state: e0 is always the head; pop shifts e1 down.
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    case ({push_i, pop_ok})
      2'b10: begin
        if (cnt_q == 2'd0) e0_d = din;
        else               e1_d = din;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        e0_d  = e1_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd2) begin
          e0_d = e1_q;
          e1_d = din;
        end else begin
          e0_d = din;
        end
      end
      default: ;
    endcase
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= '0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign count_o     = cnt_q;
  assign valid_o     = (cnt_q != 2'd0);
  assign head_data_o = e0_q[W-1:TAG_W];
  assign head_tag_o  = e0_q[TAG_W-1:0];

  a_no_overflow: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    !(push_i && !pop_ok && (cnt_q == 2'd2)));

endmodule

// File: rtl/core_alu_arb.sv
// Round-robin arbiter sharing the registered-input core ALU.
// Tracks one in-flight op and routes results to per-requester FIFOs.
module core_alu_arb
  import core_alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*3-1:0]      req_op_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_a_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_b_i,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag_i,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  input  logic [NUM_REQ-1:0]        rsp_ready_i,
  output logic [NUM_REQ*DATA_W-1:0] rsp_data_o,
  output logic [NUM_REQ*TAG_W-1:0]  rsp_tag_o,
  output logic [2:0]                alu_op_o,
  output logic [DATA_W-1:0]         alu_a_o,
  output logic [DATA_W-1:0]         alu_b_o,
  input  logic [DATA_W-1:0]         alu_c_i,
  output logic                      busy_o
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef logic [PTR_W-1:0] idx_t;
  typedef logic [PTR_W:0]   scan_t;

  idx_t             ptr_q, ptr_d;
  logic             fl_v_q;
  idx_t             fl_own_q;
  logic [TAG_W-1:0] fl_tag_q;
  logic             busy_q, busy_d;

  logic [NUM_REQ-1:0] pop, push, elig, gnt;
  logic [1:0]         cnt   [NUM_REQ];
  logic [2:0]         outst [NUM_REQ];
  logic               any_gnt;
  idx_t               gnt_idx;
  logic [TAG_W-1:0]   gnt_tag;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign pop[i]   = rsp_valid_o[i] & rsp_ready_i[i];
    assign push[i]  = fl_v_q && (fl_own_q == idx_t'(i));
    assign outst[i] = {1'b0, cnt[i]} + {2'b0, push[i]};
    assign elig[i]  = req_valid_i[i] &&
                      ((outst[i] - {2'b0, pop[i]}) < 3'd2);

    core_alu_rsp_fifo #(
      .TAG_W(TAG_W)
    ) u_fifo (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .push_i     (push[i]),
      .push_data_i(alu_c_i),
      .push_tag_i (fl_tag_q),
      .pop_i      (pop[i]),
      .count_o    (cnt[i]),
      .valid_o    (rsp_valid_o[i]),
      .head_data_o(rsp_data_o[i*DATA_W +: DATA_W]),
      .head_tag_o (rsp_tag_o[i*TAG_W +: TAG_W])
    );

    a_outst_max: assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      outst[i] <= 3'd2);
  end

  // First eligible requester at or after the pointer, wrapping.
  always_comb begin : p_grant
    scan_t scan;
    scan    = '0;
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, ptr_q} + scan_t'(k);
      if (scan >= scan_t'(NUM_REQ))
        scan = scan - scan_t'(NUM_REQ);
      if (!any_gnt && elig[scan[PTR_W-1:0]]) begin
        any_gnt = 1'b1;
        gnt_idx = scan[PTR_W-1:0];
      end
    end
    gnt[gnt_idx] = any_gnt;
  end

  assign req_ready_o = gnt;

  // Steer the granted fields to the ALU; idle drives ADD 0+0.
  always_comb begin
    alu_op_o = '0;
    alu_a_o  = '0;
    alu_b_o  = '0;
    gnt_tag  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        alu_op_o = req_op_i[i*3 +: 3];
        alu_a_o  = req_a_i[i*DATA_W +: DATA_W];
        alu_b_o  = req_b_i[i*DATA_W +: DATA_W];
        gnt_tag  = req_tag_i[i*TAG_W +: TAG_W];
      end
    end
  end

  // Pointer moves past the winner; holds when idle.
  always_comb begin
    ptr_d = ptr_q;
    if (any_gnt) begin
      if (gnt_idx == idx_t'(NUM_REQ-1)) ptr_d = '0;
      else                              ptr_d = gnt_idx + idx_t'(1);
    end
  end

  // Busy reflects next-cycle state so it can be a flop.
  always_comb begin
    busy_d = any_gnt | fl_v_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if ((cnt[i] == 2'd2) || ((cnt[i] == 2'd1) && !pop[i]))
        busy_d = 1'b1;
    end
  end

  // Pointer, in-flight stage and busy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q    <= '0;
      fl_v_q   <= 1'b0;
      fl_own_q <= '0;
      fl_tag_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      fl_v_q   <= any_gnt;
      fl_own_q <= gnt_idx;
      fl_tag_q <= gnt_tag;
      busy_q   <= busy_d;
    end
  end

  assign busy_o = busy_q;

  a_onehot: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    $onehot0(req_ready_o));

  a_rdy_vld: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (req_ready_o & ~req_valid_i) == '0);

endmodule

// File: tb/tb_core_alu_arb.sv
// Bench for core_alu_arb: registered ALU model, queue-level
// reference model checked every cycle, plus directed literals.
module tb_core_alu_arb;
  import core_alu_pkg::*;

  localparam int NR = 2;
  localparam int TW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*3-1:0] req_op;
  logic [NR*16-1:0] req_a;
  logic [NR*16-1:0] req_b;
  logic [NR*TW-1:0] req_tag;
  logic [NR-1:0]   rsp_valid;
  logic [NR-1:0]   rsp_ready;
  logic [NR*16-1:0] rsp_data;
  logic [NR*TW-1:0] rsp_tag;
  logic [2:0]      alu_op;
  logic [15:0]     alu_a;
  logic [15:0]     alu_b;
  logic [15:0]     alu_c = '0;
  logic            busy;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  core_alu_arb #(.NUM_REQ(NR), .TAG_W(TW)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_op_i   (req_op),
    .req_a_i    (req_a),
    .req_b_i    (req_b),
    .req_tag_i  (req_tag),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_data_o (rsp_data),
    .rsp_tag_o  (rsp_tag),
    .alu_op_o   (alu_op),
    .alu_a_o    (alu_a),
    .alu_b_o    (alu_b),
    .alu_c_i    (alu_c),
    .busy_o     (busy)
  );

  function automatic logic [15:0] alu_f(
    logic [2:0] op, logic [15:0] a, logic [15:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a ^ b;
      3'd4: return a << b[3:0];
      3'd5: return a >> b[3:0];
      3'd6: return a;
      default: return b;
    endcase
  endfunction

  // The core ALU: one register stage between inputs and c.
  always @(posedge clk) alu_c <= alu_f(alu_op, alu_a, alu_b);

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // ---------------- reference model ----------------
  int          mptr;
  bit          mfv;
  int          mfo;
  logic [19:0] mfe;
  logic [19:0] mbuf [NR][2];
  int          mcnt [NR];
  bit [NR-1:0] epop;
  bit          eg_v;
  int          eg_idx;
  logic [NR-1:0] ev, erdy;
  bit          eb;
  int          idx, outs;

  task automatic mclear();
    mptr = 0;
    mfv  = 1'b0;
    mfo  = 0;
    for (int i = 0; i < NR; i++) mcnt[i] = 0;
    epop = '0;
    eg_v = 1'b0;
  endtask

  initial begin
    mclear();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_rsp_valid", rsp_valid, '0);
        chk("rst_busy", busy, 0);
        mclear();
      end else begin
        eb = mfv;
        for (int i = 0; i < NR; i++) begin
          ev[i]   = (mcnt[i] > 0);
          eb      = eb | ev[i];
          epop[i] = ev[i] && rsp_ready[i];
          if (ev[i]) begin
            chk("m_rsp_data", rsp_data[i*16 +: 16], mbuf[i][0][19:4]);
            chk("m_rsp_tag", rsp_tag[i*TW +: TW], mbuf[i][0][3:0]);
          end
        end
        chk("m_rsp_valid", rsp_valid, ev);
        chk("m_busy", busy, eb);
        eg_v   = 1'b0;
        eg_idx = 0;
        for (int k = 0; k < NR; k++) begin
          idx  = (mptr + k) % NR;
          outs = mcnt[idx] + ((mfv && mfo == idx) ? 1 : 0)
                 - (epop[idx] ? 1 : 0);
          if (!eg_v && req_valid[idx] && outs < 2) begin
            eg_v   = 1'b1;
            eg_idx = idx;
          end
        end
        erdy = '0;
        if (eg_v) erdy[eg_idx] = 1'b1;
        chk("m_ready", req_ready, erdy);
        chk("m_alu_op", alu_op, eg_v ? req_op[eg_idx*3 +: 3] : 3'd0);
        chk("m_alu_a", alu_a, eg_v ? req_a[eg_idx*16 +: 16] : 16'd0);
        chk("m_alu_b", alu_b, eg_v ? req_b[eg_idx*16 +: 16] : 16'd0);
      end
      @(posedge clk);
      if (!rst_n) begin
        mclear();
      end else begin
        for (int i = 0; i < NR; i++) begin
          if (epop[i]) begin
            mbuf[i][0] = mbuf[i][1];
            mcnt[i]--;
          end
        end
        if (mfv) begin
          if (mcnt[mfo] >= 2) begin
            n_chk++;
            $display("FAIL buf_overflow: req %0d count %0d", mfo, mcnt[mfo]);
          end else begin
            mbuf[mfo][mcnt[mfo]] = mfe;
            mcnt[mfo]++;
          end
        end
        mfv = eg_v;
        if (eg_v) begin
          mfo  = eg_idx;
          mfe  = {alu_f(req_op[eg_idx*3 +: 3], req_a[eg_idx*16 +: 16],
                        req_b[eg_idx*16 +: 16]),
                  req_tag[eg_idx*TW +: TW]};
          mptr = (eg_idx + 1) % NR;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int i, logic v, logic [2:0] op,
                         logic [15:0] a, logic [15:0] b, logic [3:0] t);
    req_valid[i]        = v;
    req_op[i*3 +: 3]    = op;
    req_a[i*16 +: 16]   = a;
    req_b[i*16 +: 16]   = b;
    req_tag[i*TW +: TW] = t;
  endtask

  task automatic idle_all();
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 3'd0, 16'd0, 16'd0, 4'd0);
  endtask

  task automatic do_reset();
    cyc();
    rst_n = 1'b0;
    idle_all();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    rsp_ready = '0;
    idle_all();
    @(negedge clk);
    chk("reset_rsp_valid", rsp_valid, '0);
    chk("reset_busy", busy, 0);
    chk("reset_alu_op", alu_op, 0);
    chk("reset_alu_a", alu_a, 0);
    chk("reset_alu_b", alu_b, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single op: SUB 0x10-3, tag 5.
    rsp_ready = 2'b11;
    set_req(0, 1'b1, ALU_SUB, 16'h0010, 16'h0003, 4'd5);
    @(negedge clk);
    chk("single_ready", req_ready, 2'b01);
    chk("single_alu_op", alu_op, 3'd1);
    chk("single_alu_a", alu_a, 16'h0010);
    chk("single_alu_b", alu_b, 16'h0003);
    cyc();
    idle_all();
    @(negedge clk);
    chk("single_busy_c1", busy, 1);
    chk("single_novalid_c1", rsp_valid, 2'b00);
    cyc();
    @(negedge clk);
    chk("single_valid_c2", rsp_valid, 2'b01);
    chk("single_data", rsp_data[15:0], 16'h000D);
    chk("single_tag", rsp_tag[3:0], 4'd5);
    chk("single_busy_c2", busy, 1);
    cyc();
    @(negedge clk);
    chk("single_busy_c3", busy, 0);

    // Contention: alternating grants.
    do_reset();
    rsp_ready = 2'b11;
    set_req(0, 1'b1, ALU_ADD, 16'h0001, 16'h0001, 4'd1);
    set_req(1, 1'b1, ALU_XOR, 16'hFFFF, 16'h00FF, 4'd2);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("cont_ready", req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
      if (c == 2) chk("cont_data0", rsp_data[15:0], 16'h0002);
      if (c == 3) chk("cont_data1", rsp_data[31:16], 16'hFF00);
      cyc();
    end
    idle_all();
    repeat (4) cyc();

    // Backpressure and full-buffer pop with same-cycle grant.
    do_reset();
    rsp_ready = 2'b00;
    set_req(0, 1'b1, ALU_SHL, 16'h0001, 16'd0, 4'd0);
    @(negedge clk);
    chk("bp_grant0", req_ready, 2'b01);
    cyc();
    set_req(0, 1'b1, ALU_SHL, 16'h0001, 16'd1, 4'd1);
    @(negedge clk);
    chk("bp_grant1", req_ready, 2'b01);
    cyc();
    set_req(0, 1'b1, ALU_SHL, 16'h0001, 16'd2, 4'd2);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("bp_stall", req_ready, 2'b00);
      cyc();
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    chk("full_pop_grant", req_ready, 2'b01);
    chk("bp_pop0", rsp_data[15:0], 16'h0001);
    cyc();
    set_req(0, 1'b1, ALU_SHL, 16'h0001, 16'd3, 4'd3);
    @(negedge clk);
    chk("bp_grant3", req_ready, 2'b01);
    chk("bp_pop1", rsp_data[15:0], 16'h0002);
    cyc();
    idle_all();
    @(negedge clk);
    chk("bp_pop2", rsp_data[15:0], 16'h0004);
    repeat (4) cyc();

    // Reset while PASS_B is in flight.
    rsp_ready = 2'b11;
    set_req(1, 1'b1, ALU_PASS_B, 16'h0000, 16'hBEEF, 4'd7);
    @(negedge clk);
    chk("rmf_grant", req_ready, 2'b10);
    cyc();
    idle_all();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rmf_valid", rsp_valid, 2'b00);
    chk("rmf_busy", busy, 0);
    cyc();
    cyc();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rmf_no_ghost", rsp_valid, 2'b00);
      cyc();
    end

    // Idle drive and pointer hold.
    set_req(0, 1'b1, ALU_ADD, 16'h0002, 16'h0003, 4'd1);
    @(negedge clk);
    chk("idle_pre_grant", req_ready, 2'b01);
    cyc();
    idle_all();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("idle_op", alu_op, 0);
      chk("idle_a", alu_a, 0);
      chk("idle_b", alu_b, 0);
      cyc();
    end
    set_req(0, 1'b1, ALU_AND, 16'h00F0, 16'h0FF0, 4'd3);
    set_req(1, 1'b1, ALU_SHR, 16'h8000, 16'd4, 4'd4);
    @(negedge clk);
    chk("ptr_hold", req_ready, 2'b10);
    cyc();
    idle_all();
    repeat (4) cyc();

    // Mixed traffic with irregular consumer backpressure.
    for (int c = 0; c < 60; c++) begin
      for (int i = 0; i < NR; i++)
        set_req(i, 1'($urandom), 3'($urandom), 16'($urandom),
                16'($urandom), 4'($urandom));
      rsp_ready = 2'($urandom);
      cyc();
    end
    idle_all();
    rsp_ready = 2'b11;
    repeat (6) cyc();
    @(negedge clk);
    chk("drain_busy", busy, 0);
    chk("drain_valid", rsp_valid, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/core_alu_arb.md
Name: core_alu_arb

Overview:
- Arbiter and sequencer sharing the single registered-input core ALU between NUM_REQ requesters, for example the execute stage and the debug/monitor port.
- Accepts tagged operations over a valid/ready handshake and grants at most one per cycle, round-robin.
- Drives the ALU operand and opcode inputs and tracks the in-flight operation across the ALU's one-cycle register stage.
- Returns each result, with its tag, to the originating requester through a per-requester 2-entry response buffer.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- TAG_W, 4, width of the opaque requester tag returned with each result.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  NUM_REQ  per-requester operation valid.
- req_ready_o  out  NUM_REQ  per-requester accept (one-hot or zero).
- req_op_i  in  NUM_REQ x 3  ALU opcode (alu_op_e).
- req_a_i  in  NUM_REQ x 16  operand A.
- req_b_i  in  NUM_REQ x 16  operand B.
- req_tag_i  in  NUM_REQ x TAG_W  requester tag.
- rsp_valid_o  out  NUM_REQ  result available.
- rsp_ready_i  in  NUM_REQ  requester consumes result.
- rsp_data_o  out  NUM_REQ x 16  result.
- rsp_tag_o  out  NUM_REQ x TAG_W  tag of the result.
- alu_op_o  out  3  to ALU alu_op_i.
- alu_a_o  out  16  to ALU a_i.
- alu_b_o  out  16  to ALU b_i.
- alu_c_i  in  16  from ALU c_ro.
- busy_o  out  1  any operation in flight or any response buffered.

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_ni is asynchronous, active-low. Reset clears the round-robin pointer to 0, the in-flight stage and all response buffers, and the outstanding counters.
- Outputs after reset: rsp_valid_o=0, busy_o=0, alu_op_o/alu_a_o/alu_b_o=0.
- Reset mid-operation: an in-flight ALU result is discarded and never returned.
- Eligibility: requester i is eligible when req_valid_i[i]=1 and (outstanding[i] - pop[i]) < 2.
  - outstanding[i] = (in-flight owner==i) + response-buffer occupancy of i.
  - pop[i] = rsp_valid_o[i] & rsp_ready_i[i].
- Arbitration:
  - Grant the first eligible requester at or after the pointer, searching upward and wrapping.
  - req_ready_o is combinational and equals the grant vector.
  - After a grant to index g the pointer becomes (g+1) mod NUM_REQ; with no grant it holds.
- ALU drive:
  - In a grant cycle N, alu_op_o/alu_a_o/alu_b_o are combinationally the granted requester's fields.
  - With no grant, all three are 0 (ADD 0+0); the result is ignored.
- In-flight stage:
  - At the edge ending cycle N, record valid=1, owner=g, tag.
  - In cycle N+1 alu_c_i holds the result.
  - At the edge ending N+1, write {alu_c_i, tag} into owner's response buffer.
  - rsp_valid_o[owner]=1 from cycle N+2. Minimum request-to-response latency is 2 cycles.
- Throughput: one grant per cycle overall. A single requester sustains one op per cycle if it pops every cycle.
- Response buffer:
  - 2-entry FIFO per requester. rsp_data_o/rsp_tag_o show the head entry and are registered outputs.
  - Order per requester is preserved.
  - The eligibility rule guarantees no overflow. Overflow is an assertion failure.
  - Simultaneous push and pop on the same buffer is legal at any occupancy, including full with pop.
- Boundaries:
  - Pop on an empty buffer is ignored.
  - rsp_ready_i while rsp_valid_o=0 is harmless.
  - A requester dropping req_valid_i without a grant is legal (no stickiness required).
- busy_o = in-flight valid | any buffer non-empty, registered.
- Assertions:
  - req_ready_o at most one-hot.
  - Never ready without valid.
  - outstanding[i] <= 2.

Decomposition:
- core_alu_pkg: alu_op_e enum (ADD=0, SUB=1, AND=2, XOR=3, SHL=4, SHR=5, PASS_A=6, PASS_B=7), DATA_W=16, ALU_LATENCY=1 constant.
- Sub-module core_alu_rsp_fifo: 2-entry FIFO of {data, tag}, with push, pop, count and head outputs. It is instantiated NUM_REQ times.
- The round-robin grant stays inline.

Test Plan:
- Single op: req0 sends SUB a=0x0010 b=0x0003 tag=5 at cycle 0 -> ready0=1 at cycle 0; rsp_valid0=1 at cycle 2 with data=0x000D, tag=5; busy_o=1 in cycles 1-2.
- Contention: both requesters valid every cycle after reset with ADD 1+1 (req0) and XOR 0xFFFF^0x00FF (req1), rsp_ready all 1 -> grants alternate 0,1,0,1; results 0x0002 and 0xFF00 return in order.
- Backpressure: req0 streams SHL a=1 b=k for k=0..3 with rsp_ready0=0 -> exactly 2 grants; ready0 stays 0; after rsp_ready0=1, pops return 0x0001 then 0x0002, then the remaining grants resume.
- Full plus simultaneous pop: req0 buffer full with rsp_ready0=1 and req_valid0=1 -> grant in the same cycle; no overflow, no lost result.
- Reset mid-flight: assert rst_ni=0 in the cycle after a grant of PASS_B b=0xBEEF -> all rsp_valid_o=0 and busy_o=0 immediately; no response appears after release.
- Idle drive: no requests -> alu_op_o=0, alu_a_o=0, alu_b_o=0, pointer unchanged.
